// File: rtl/axis_pkt_tx_pkg.sv
//------------------------------------------------------------------------------
// Module      : axis_pkt_tx_pkg
// Description : Shared widths, FSM state type and last-beat strobe helper
//               for the AXI-Stream packet transmitter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package axis_pkt_tx_pkg;

    localparam int TDATA_WIDTH = 128;
    localparam int TUSER_WIDTH = 8;
    localparam int BPB         = TDATA_WIDTH / 8;
    localparam int REM_WIDTH   = (BPB > 1) ? $clog2(BPB) : 1;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_t;

    // Strobe for the final beat: low 'rem' bytes valid, a zero remainder
    // means the final beat is completely full.
    function automatic logic [BPB-1:0] strb_mask(input logic [REM_WIDTH-1:0] rem);
        logic [BPB-1:0] mask;
        for (int i = 0; i < BPB; i++) begin
            mask[i] = (rem == '0) || (REM_WIDTH'(i) < rem);
        end
        return mask;
    endfunction

endpackage

`default_nettype wire

// File: rtl/axis_pkt_tx_if.sv
//------------------------------------------------------------------------------
// Module      : axi_intf
// Description : AXI-Stream bundle (valid/ready/data/last/strb/user) with
//               master and slave views.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface axi_intf #(
    parameter int TDATA_WIDTH = axis_pkt_tx_pkg::TDATA_WIDTH,
    parameter int TUSER_WIDTH = axis_pkt_tx_pkg::TUSER_WIDTH
);
    import axis_pkt_tx_pkg::*;

    logic                     tvalid;
    logic                     tready;
    logic [TDATA_WIDTH-1:0]   tdata;
    logic                     tlast;
    logic [TDATA_WIDTH/8-1:0] tstrb;
    logic [TUSER_WIDTH-1:0]   tuser;

    modport master (
        output tvalid, tdata, tlast, tstrb, tuser,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tlast, tstrb, tuser,
        output tready
    );

endinterface

`default_nettype wire

// File: rtl/axis_pkt_tx.sv
//------------------------------------------------------------------------------
// Module      : axis_pkt_tx
// Description : AXI-Stream packet transmitter. Takes a (length, user)
//               command plus a word-wide payload feed and emits the packet
//               through a single output register stage with tlast/tstrb on
//               the final beat and a registered tx_done pulse.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module axis_pkt_tx #(
    parameter int TDATA_WIDTH = axis_pkt_tx_pkg::TDATA_WIDTH,
    parameter int TUSER_WIDTH = axis_pkt_tx_pkg::TUSER_WIDTH,
    parameter int LEN_WIDTH   = 16
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic                   cmd_valid,
    output logic                        cmd_ready,
    input  wire logic [LEN_WIDTH-1:0]   cmd_len,
    input  wire logic [TUSER_WIDTH-1:0] cmd_user,
    input  wire logic                   pay_valid,
    output logic                        pay_ready,
    input  wire logic [TDATA_WIDTH-1:0] pay_data,
    axi_intf.master                     m_axis,
    output logic                        tx_done
);
    import axis_pkt_tx_pkg::*;

    localparam int NB = TDATA_WIDTH / 8;
    localparam int RW = (NB > 1) ? $clog2(NB) : 1;
    localparam int BW = LEN_WIDTH + 1;

    tx_state_t              state_q,     state_d;
    logic [BW-1:0]          beats_left_q, beats_left_d;
    logic [RW-1:0]          rem_q,       rem_d;
    logic [TUSER_WIDTH-1:0] user_q,      user_d;
    logic                   m_tvalid_q,  m_tvalid_d;
    logic [TDATA_WIDTH-1:0] m_tdata_q,   m_tdata_d;
    logic                   m_tlast_q,   m_tlast_d;
    logic [NB-1:0]          m_tstrb_q,   m_tstrb_d;
    logic [TUSER_WIDTH-1:0] m_tuser_q,   m_tuser_d;
    logic                   tx_done_q,   tx_done_d;

    logic [BW-1:0]          beats_calc;
    logic [RW-1:0]          rem_calc;
    logic [NB-1:0]          last_strb;
    logic                   pay_fire;
    logic                   last_load;

    // Beat count is widened by one bit so a maximum length cannot wrap.
    assign beats_calc = ({1'b0, cmd_len} + BW'(NB - 1)) / BW'(NB);
    assign rem_calc   = RW'(cmd_len % LEN_WIDTH'(NB));

    assign cmd_ready  = (state_q == TX_IDLE);
    assign pay_ready  = (state_q == TX_SEND) && (beats_left_q != '0)
                        && (!m_tvalid_q || m_axis.tready);
    assign pay_fire   = pay_valid && pay_ready;
    assign last_load  = (beats_left_q == BW'(1));

    // Final-beat strobe: the low 'rem' bytes, or every byte when rem is zero.
    always_comb begin
        last_strb = '0;
        for (int i = 0; i < NB; i++) begin
            last_strb[i] = (rem_q == '0) || (RW'(i) < rem_q);
        end
    end

    // Next-state logic for the FSM, beat counter and output register.
    always_comb begin
        state_d      = state_q;
        beats_left_d = beats_left_q;
        rem_d        = rem_q;
        user_d       = user_q;
        m_tvalid_d   = m_tvalid_q;
        m_tdata_d    = m_tdata_q;
        m_tlast_d    = m_tlast_q;
        m_tstrb_d    = m_tstrb_q;
        m_tuser_d    = m_tuser_q;
        tx_done_d    = m_tvalid_q && m_axis.tready && m_tlast_q;

        case (state_q)
            TX_IDLE: begin
                // A zero-length command is consumed without leaving idle.
                if (cmd_valid && (cmd_len != '0)) begin
                    state_d      = TX_SEND;
                    beats_left_d = beats_calc;
                    rem_d        = rem_calc;
                    user_d       = cmd_user;
                end
            end
            TX_SEND: begin
                if (pay_fire && last_load) begin
                    state_d = TX_IDLE;
                end
            end
            default: state_d = TX_IDLE;
        endcase

        if (pay_fire) begin
            beats_left_d = beats_left_q - BW'(1);
            m_tvalid_d   = 1'b1;
            m_tlast_d    = last_load;
            m_tstrb_d    = last_load ? last_strb : '1;
            m_tuser_d    = user_q;
            // Bytes outside the strobe are zeroed so stale payload never leaks.
            for (int i = 0; i < NB; i++) begin
                m_tdata_d[8*i +: 8] = m_tstrb_d[i] ? pay_data[8*i +: 8] : 8'h00;
            end
        end else if (m_tvalid_q && m_axis.tready) begin
            m_tvalid_d = 1'b0;
        end
    end

    // State and output register; reset truncates any packet in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= TX_IDLE;
            beats_left_q <= '0;
            rem_q        <= '0;
            user_q       <= '0;
            m_tvalid_q   <= 1'b0;
            m_tdata_q    <= '0;
            m_tlast_q    <= 1'b0;
            m_tstrb_q    <= '0;
            m_tuser_q    <= '0;
            tx_done_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            beats_left_q <= beats_left_d;
            rem_q        <= rem_d;
            user_q       <= user_d;
            m_tvalid_q   <= m_tvalid_d;
            m_tdata_q    <= m_tdata_d;
            m_tlast_q    <= m_tlast_d;
            m_tstrb_q    <= m_tstrb_d;
            m_tuser_q    <= m_tuser_d;
            tx_done_q    <= tx_done_d;
        end
    end

    assign m_axis.tvalid = m_tvalid_q;
    assign m_axis.tdata  = m_tdata_q;
    assign m_axis.tlast  = m_tlast_q;
    assign m_axis.tstrb  = m_tstrb_q;
    assign m_axis.tuser  = m_tuser_q;
    assign tx_done       = tx_done_q;

endmodule

`default_nettype wire

// File: tb/tb_axis_pkt_tx.sv
//------------------------------------------------------------------------------
// Module      : tb_axis_pkt_tx
// Description : Self-checking bench for axis_pkt_tx with a packet-level
//               reference model and randomized valid/ready gaps.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_axis_pkt_tx;

    localparam int DW = 128;
    localparam int UW = 8;
    localparam int LW = 16;
    localparam int NB = DW / 8;

    typedef struct {
        logic [DW-1:0] data;
        logic [NB-1:0] strb;
        logic          last;
        logic [UW-1:0] user;
        logic          first;
    } beat_t;

    typedef struct {
        logic [LW-1:0] len;
        logic [UW-1:0] user;
    } cmd_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [LW-1:0] cmd_len = '0;
    logic [UW-1:0] cmd_user = '0;
    logic          pay_valid = 1'b0;
    logic          pay_ready;
    logic [DW-1:0] pay_data = '0;
    logic          tx_done;

    axi_intf #(.TDATA_WIDTH(DW), .TUSER_WIDTH(UW)) m_if ();

    axis_pkt_tx #(
        .TDATA_WIDTH (DW),
        .TUSER_WIDTH (UW),
        .LEN_WIDTH   (LW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_len   (cmd_len),
        .cmd_user  (cmd_user),
        .pay_valid (pay_valid),
        .pay_ready (pay_ready),
        .pay_data  (pay_data),
        .m_axis    (m_if),
        .tx_done   (tx_done)
    );

    always #5 clk = ~clk;

    cmd_t          cmd_q[$];
    logic [DW-1:0] pay_q[$];
    beat_t         exp_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int p_pay = 100;
    int p_rdy = 100;
    bit full_rate = 1'b0;
    bit exp_done = 1'b0;
    bit prev_hold = 1'b0;
    int cmd_fire_cyc = 0;
    int last_beat_cyc = 0;
    logic [DW-1:0] prev_data;
    logic [NB-1:0] prev_strb;
    logic          prev_last;
    logic [UW-1:0] prev_user;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Model: a packet of len bytes is ceil(len/NB) words; the final word keeps
    // only its first (len - NB*k) bytes, everything above reads as zero.
    task automatic enqueue(input int len, input logic [UW-1:0] user);
        cmd_t          c;
        beat_t         b;
        int            nbeats;
        int            vb;
        logic [DW-1:0] w;
        c.len  = LW'(len);
        c.user = user;
        cmd_q.push_back(c);
        nbeats = (len + NB - 1) / NB;
        for (int k = 0; k < nbeats; k++) begin
            w = {$urandom, $urandom, $urandom, $urandom};
            pay_q.push_back(w);
            vb = (k == nbeats - 1) ? (len - NB * k) : NB;
            b.data = '0;
            b.strb = '0;
            for (int j = 0; j < vb; j++) begin
                b.data[8*j +: 8] = w[8*j +: 8];
                b.strb[j]        = 1'b1;
            end
            b.last  = (k == nbeats - 1);
            b.user  = user;
            b.first = (k == 0);
            exp_q.push_back(b);
        end
    endtask

    // One clock cycle: drive at the falling edge, sample 1 ns later and
    // account for the handshakes that the next rising edge will complete.
    task automatic step();
        beat_t b;
        bit    last_f;
        @(negedge clk);
        cyc++;
        cmd_valid = (cmd_q.size() > 0) && ($urandom_range(99) < p_pay);
        if (cmd_q.size() > 0) begin
            cmd_len  = cmd_q[0].len;
            cmd_user = cmd_q[0].user;
        end
        pay_valid = (pay_q.size() > 0) && ($urandom_range(99) < p_pay);
        pay_data  = (pay_q.size() > 0) ? pay_q[0] : {$urandom, $urandom, $urandom, $urandom};
        m_if.tready = ($urandom_range(99) < p_rdy);
        #1;
        check("tx_done", tx_done, exp_done);
        if (prev_hold) begin
            check("hold_tvalid", m_if.tvalid, 1'b1);
            check("hold_tdata",  m_if.tdata,  prev_data);
            check("hold_tstrb",  m_if.tstrb,  prev_strb);
            check("hold_tlast",  m_if.tlast,  prev_last);
            check("hold_tuser",  m_if.tuser,  prev_user);
        end
        if (exp_q.size() == 0) check("idle_tvalid", m_if.tvalid, 1'b0);
        last_f = 1'b0;
        if (m_if.tvalid && m_if.tready && exp_q.size() > 0) begin
            b = exp_q.pop_front();
            check("tdata", m_if.tdata, b.data);
            check("tstrb", m_if.tstrb, b.strb);
            check("tlast", m_if.tlast, b.last);
            check("tuser", m_if.tuser, b.user);
            if (full_rate) begin
                if (b.first) check("first_latency", cyc - cmd_fire_cyc, 2);
                else         check("beat_gap", cyc - last_beat_cyc, 1);
            end
            last_beat_cyc = cyc;
            last_f = b.last;
        end
        exp_done  = last_f;
        prev_hold = m_if.tvalid && !m_if.tready;
        prev_data = m_if.tdata;
        prev_strb = m_if.tstrb;
        prev_last = m_if.tlast;
        prev_user = m_if.tuser;
        if (pay_valid && pay_ready) void'(pay_q.pop_front());
        if (cmd_valid && cmd_ready) begin
            void'(cmd_q.pop_front());
            cmd_fire_cyc = cyc;
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((cmd_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
            step();
            n++;
        end
        check("drain_left", cmd_q.size() + exp_q.size(), 0);
        step();
        step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tvalid"},    m_if.tvalid, 1'b0);
        check({tag, "_tdata"},     m_if.tdata,  '0);
        check({tag, "_tlast"},     m_if.tlast,  1'b0);
        check({tag, "_tstrb"},     m_if.tstrb,  '0);
        check({tag, "_tuser"},     m_if.tuser,  '0);
        check({tag, "_tx_done"},   tx_done,     1'b0);
        check({tag, "_pay_ready"}, pay_ready,   1'b0);
        check({tag, "_cmd_ready"}, cmd_ready,   1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        m_if.tready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Full-rate 3-beat packet.
        full_rate = 1'b1; p_pay = 100; p_rdy = 100;
        enqueue(48, 8'hA1);
        drain(50);

        // Short final beat: one valid byte, upper bytes forced to zero.
        enqueue(17, 8'hA2);
        drain(50);

        // Stall a single 5-byte beat for four cycles.
        full_rate = 1'b0; p_rdy = 0;
        enqueue(5, 8'hA3);
        for (int i = 0; i < 20 && !m_if.tvalid; i++) step();
        check("stall_seen", m_if.tvalid, 1'b1);
        repeat (4) step();
        p_rdy = 100;
        drain(50);

        // Back-to-back commands with random gaps on both sides.
        p_pay = 60; p_rdy = 50;
        enqueue(32, 8'hB1);
        enqueue(16, 8'hB2);
        drain(300);

        // Zero-length command followed by a single full beat.
        full_rate = 1'b1; p_pay = 100; p_rdy = 100;
        enqueue(0, 8'hC0);
        enqueue(16, 8'hC1);
        drain(50);

        // Random lengths, including zero, under random gaps.
        full_rate = 1'b0; p_pay = 70; p_rdy = 60;
        for (int i = 0; i < 20; i++) enqueue($urandom_range(0, 80), UW'($urandom));
        drain(2000);

        // Maximum length: 4096 beats, 15 bytes on the last.
        full_rate = 1'b1; p_pay = 100; p_rdy = 100;
        enqueue(65535, 8'hE1);
        drain(6000);

        // Reset in the middle of a packet, between clock edges.
        enqueue(64, 8'hD1);
        for (int i = 0; i < 20 && exp_q.size() > 2; i++) step();
        #2;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        pay_valid = 1'b0;
        #1;
        check_reset_outputs("midrst");
        cmd_q.delete();
        pay_q.delete();
        exp_q.delete();
        exp_done  = 1'b0;
        prev_hold = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        enqueue(16, 8'hD2);
        drain(50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
